// File: rtl/elevator_dispatcher_pkg.sv
// Shared encodings for the elevator dispatcher: FSM states and travel direction.
package elevator_dispatcher_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_STOP      = 3'd3,
    ST_DOOR      = 3'd4,
    ST_FAULT     = 3'd5
  } disp_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/elevator_dispatcher_call_request_reg.sv
// Pending call register: latches call buttons, clears the served floor,
// and reduces the pending set into above / below / here flags.
module call_request_reg
  import elevator_dispatcher_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_FLOORS-1:0] i_call,
  input  logic [FLOOR_W-1:0]    i_floor,
  input  logic                  i_clear_en,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_above,
  output logic                  o_below,
  output logic                  o_here
);

  localparam logic [NUM_FLOORS-1:0] ONE_BIT = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_clear_mask;
  logic                  w_above;
  logic                  w_below;

  // Select the current-floor bit for clearing while the car is stopped there
  always_comb begin
    w_clear_mask = {NUM_FLOORS{1'b0}};
    if (i_clear_en) begin
      w_clear_mask = ONE_BIT << i_floor;
    end else begin
      w_clear_mask = {NUM_FLOORS{1'b0}};
    end
  end

  // Accumulate new calls and drop the floor being served
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= {NUM_FLOORS{1'b0}};
    end else begin
      r_pending <= (r_pending | i_call) & ~w_clear_mask;
    end
  end

  // Reduce pending calls strictly above / strictly below the current floor
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(i_floor)) begin
        w_above = w_above | r_pending[i];
      end else if (i < int'(i_floor)) begin
        w_below = w_below | r_pending[i];
      end else begin
        w_above = w_above;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_above   = w_above;
  assign o_below   = w_below;
  assign o_here    = r_pending[i_floor];

endmodule

// File: rtl/elevator_dispatcher.sv
// Elevator dispatcher: tracks car floor, serves calls in the travel direction
// before reversing, holds the door for a fixed dwell, and issues one of
// Go_Up / Go_Down / Halt to the car FSM every cycle.
module elevator_dispatcher
  import elevator_dispatcher_pkg::*;
#(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_FLOORS-1:0] Call_Req,
  input  logic                  Floor_Reached,
  input  logic                  Top_Limit_Hit,
  input  logic                  Bottom_Limit_Hit,
  output logic                  Go_Up,
  output logic                  Go_Down,
  output logic                  Halt,
  output logic [FLOOR_W-1:0]    Current_Floor,
  output logic [NUM_FLOORS-1:0] Pending,
  output logic                  Door_Open,
  output logic                  Busy,
  output logic [2:0]            Disp_State
);

  localparam int                 CNT_W      = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   DWELL_LOAD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR  = {FLOOR_W{1'b0}};
  localparam logic [FLOOR_W-1:0] FLOOR_ONE  = FLOOR_W'(1);

  disp_state_t           r_state;
  dir_t                  r_dir;
  logic [FLOOR_W-1:0]    r_floor;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_go_up;
  logic                  r_go_down;
  logic                  r_halt;
  logic                  r_door;
  logic                  r_busy;

  logic [NUM_FLOORS-1:0] w_pending;
  logic                  w_above;
  logic                  w_below;
  logic                  w_here;
  logic                  w_clear_en;
  logic [FLOOR_W-1:0]    w_floor_inc;
  logic [FLOOR_W-1:0]    w_floor_dec;
  logic [FLOOR_W-1:0]    w_floor_aligned;
  logic                  w_stop_inc;
  logic                  w_stop_dec;
  logic                  w_pick_up;
  logic                  w_here_call;
  logic                  w_fault;

  assign w_clear_en = (r_state == ST_STOP) || (r_state == ST_DOOR);

  call_request_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_call_request_reg (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_call     (Call_Req),
    .i_floor    (r_floor),
    .i_clear_en (w_clear_en),
    .o_pending  (w_pending),
    .o_above    (w_above),
    .o_below    (w_below),
    .o_here     (w_here)
  );

  // Next-floor candidates, stop decisions, direction choice and fault detection
  always_comb begin
    w_floor_inc = r_floor;
    w_floor_dec = r_floor;
    if (r_floor == TOP_FLOOR) begin
      w_floor_inc = TOP_FLOOR;
    end else begin
      w_floor_inc = r_floor + FLOOR_ONE;
    end
    if (r_floor == BOT_FLOOR) begin
      w_floor_dec = BOT_FLOOR;
    end else begin
      w_floor_dec = r_floor - FLOOR_ONE;
    end
    w_stop_inc  = w_pending[w_floor_inc] || (w_floor_inc == TOP_FLOOR);
    w_stop_dec  = w_pending[w_floor_dec] || (w_floor_dec == BOT_FLOOR);
    w_pick_up   = w_above && ((r_dir == DIR_UP) || !w_below);
    w_here_call = Call_Req[r_floor];
    w_fault     = (Top_Limit_Hit && Bottom_Limit_Hit)
               || ((r_state == ST_MOVE_UP)   && Bottom_Limit_Hit)
               || ((r_state == ST_MOVE_DOWN) && Top_Limit_Hit);
  end

  // Stationary realignment: a single limit switch snaps the tracked floor
  always_comb begin
    w_floor_aligned = r_floor;
    if (Top_Limit_Hit && !Bottom_Limit_Hit) begin
      w_floor_aligned = TOP_FLOOR;
    end else if (Bottom_Limit_Hit && !Top_Limit_Hit) begin
      w_floor_aligned = BOT_FLOOR;
    end else begin
      w_floor_aligned = r_floor;
    end
  end

  // Dispatcher FSM with floor tracker, dwell counter and registered commands
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_UP;
      r_floor   <= BOT_FLOOR;
      r_cnt     <= {CNT_W{1'b0}};
      r_go_up   <= 1'b0;
      r_go_down <= 1'b0;
      r_halt    <= 1'b1;
      r_door    <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_fault) begin
      r_state   <= ST_FAULT;
      r_go_up   <= 1'b0;
      r_go_down <= 1'b0;
      r_halt    <= 1'b1;
      r_door    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_floor <= w_floor_aligned;
          if (w_here) begin
            r_state <= ST_STOP;
            r_busy  <= 1'b1;
          end else if (w_pick_up) begin
            r_state <= ST_MOVE_UP;
            r_dir   <= DIR_UP;
            r_go_up <= 1'b1;
            r_halt  <= 1'b0;
            r_busy  <= 1'b1;
          end else if (w_below) begin
            r_state   <= ST_MOVE_DOWN;
            r_dir     <= DIR_DOWN;
            r_go_down <= 1'b1;
            r_halt    <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MOVE_UP: begin
          if (Top_Limit_Hit) begin
            r_floor <= TOP_FLOOR;
            r_state <= ST_STOP;
            r_go_up <= 1'b0;
            r_halt  <= 1'b1;
          end else if (Floor_Reached) begin
            r_floor <= w_floor_inc;
            if (w_stop_inc) begin
              r_state <= ST_STOP;
              r_go_up <= 1'b0;
              r_halt  <= 1'b1;
            end else begin
              r_state <= ST_MOVE_UP;
            end
          end else begin
            r_state <= ST_MOVE_UP;
          end
        end
        ST_MOVE_DOWN: begin
          if (Bottom_Limit_Hit) begin
            r_floor   <= BOT_FLOOR;
            r_state   <= ST_STOP;
            r_go_down <= 1'b0;
            r_halt    <= 1'b1;
          end else if (Floor_Reached) begin
            r_floor <= w_floor_dec;
            if (w_stop_dec) begin
              r_state   <= ST_STOP;
              r_go_down <= 1'b0;
              r_halt    <= 1'b1;
            end else begin
              r_state <= ST_MOVE_DOWN;
            end
          end else begin
            r_state <= ST_MOVE_DOWN;
          end
        end
        ST_STOP: begin
          r_floor <= w_floor_aligned;
          r_cnt   <= DWELL_LOAD;
          r_state <= ST_DOOR;
          r_door  <= 1'b1;
        end
        ST_DOOR: begin
          r_floor <= w_floor_aligned;
          if (w_here_call) begin
            r_cnt <= DWELL_LOAD;
          end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_door <= 1'b0;
            if (w_pick_up) begin
              r_state <= ST_MOVE_UP;
              r_dir   <= DIR_UP;
              r_go_up <= 1'b1;
              r_halt  <= 1'b0;
            end else if (w_below) begin
              r_state   <= ST_MOVE_DOWN;
              r_dir     <= DIR_DOWN;
              r_go_down <= 1'b1;
              r_halt    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          r_floor <= w_floor_aligned;
          r_state <= ST_FAULT;
        end
        default: begin
          r_state   <= ST_FAULT;
          r_go_up   <= 1'b0;
          r_go_down <= 1'b0;
          r_halt    <= 1'b1;
          r_door    <= 1'b0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign Go_Up         = r_go_up;
  assign Go_Down       = r_go_down;
  assign Halt          = r_halt;
  assign Current_Floor = r_floor;
  assign Pending       = w_pending;
  assign Door_Open     = r_door;
  assign Busy          = r_busy;
  assign Disp_State    = r_state;

endmodule
